banked_mem: RTL and testbench

Parametrised banked word memory with a valid/ready request port, per-byte write enables and registered read responses. The upper address bits select one of NUM_BANKS banks; the lower bits index a row. Each bank is split into byte lanes. After every reset, a built-in init sequencer zeroes the whole array before the block accepts any request. A one-hot output mux drives the response bus; there are no tristate drivers.

---
 rtl/banked_mem_pkg.sv | 21 ++
 rtl/banked_mem_bank_ram.sv | 38 +++
 rtl/banked_mem.sv | 128 ++++++++++++
 tb/tb_banked_mem.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
// Shared types and derived-constant helpers for the banked word memory.
package banked_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_lanes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic int calc_rows(input int addr_w, input int bank_bits);
        return 2 ** (addr_w - bank_bits);
    endfunction

    function automatic int calc_banks(input int bank_bits);
        return 2 ** bank_bits;
    endfunction

endpackage

// File: rtl/banked_mem_bank_ram.sv
// One memory bank: independent byte-lane arrays with per-lane write enables
// and a read register that only updates on a read strobe.
module bank_ram #(
    parameter int BYTE_W = 8,
    parameter int LANES  = 4,
    parameter int ROW_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        we,
    input  logic                    re,
    input  logic [ROW_W-1:0]        addr,
    input  logic [LANES*BYTE_W-1:0] wdata,
    output logic [LANES*BYTE_W-1:0] rdata
);

    localparam int ROWS = 2 ** ROW_W;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [BYTE_W-1:0] mem [ROWS];

        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[addr] <= wdata[l*BYTE_W +: BYTE_W];
            end
        end

        // Only the read register is reset; it doubles as the response data hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata[l*BYTE_W +: BYTE_W] <= '0;
            end else if (re) begin
                rdata[l*BYTE_W +: BYTE_W] <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/banked_mem.sv
// Banked word memory with valid/ready request port, byte enables, one-cycle
// registered read response and a post-reset zeroing sequencer.
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int BANK_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/BYTE_W-1:0]  req_be,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [BANK_BITS-1:0]      rsp_bank,
    output logic                      init_busy
);

    localparam int LANES     = calc_lanes(DATA_W, BYTE_W);
    localparam int ROWS      = calc_rows(ADDR_W, BANK_BITS);
    localparam int NUM_BANKS = calc_banks(BANK_BITS);
    localparam int ROW_W     = ADDR_W - BANK_BITS;

    if (DATA_W % BYTE_W != 0) begin : g_bad_lane_width
        $error("banked_mem: DATA_W must be a multiple of BYTE_W");
    end
    if (BANK_BITS >= ADDR_W) begin : g_bad_bank_bits
        $error("banked_mem: BANK_BITS must be less than ADDR_W");
    end

    state_t                 state;
    logic [ROW_W-1:0]       row_cnt;
    logic [BANK_BITS-1:0]   req_bank;
    logic [ROW_W-1:0]       req_row;
    logic [NUM_BANKS-1:0]   bank_oh;
    logic                   xfer;
    logic                   clearing;
    logic [ROW_W-1:0]       ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic [DATA_W-1:0]      bank_rdata [NUM_BANKS];

    assign req_bank  = req_addr[ADDR_W-1 -: BANK_BITS];
    assign req_row   = req_addr[ROW_W-1:0];
    assign bank_oh   = NUM_BANKS'(1) << req_bank;
    assign xfer      = req_valid && req_ready && !rst;
    assign clearing  = (state == INIT) && !rst;
    assign ram_addr  = (state == INIT) ? row_cnt : req_row;
    assign ram_wdata = (state == INIT) ? '0 : req_wdata;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [LANES-1:0] we;
        logic             re;

        always_comb begin
            we = '0;
            if (clearing) begin
                we = '1;
            end else if (xfer && req_write && bank_oh[b]) begin
                we = req_be;
            end
        end

        assign re = xfer && !req_write && bank_oh[b];

        bank_ram #(
            .BYTE_W(BYTE_W),
            .LANES (LANES),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (we),
            .re   (re),
            .addr (ram_addr),
            .wdata(ram_wdata),
            .rdata(bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            row_cnt   <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_bank  <= '0;
        end else begin
            rsp_valid <= xfer && !req_write;
            if (xfer && !req_write) begin
                rsp_bank <= req_bank;
            end
            case (state)
                INIT: begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt == ROW_W'(ROWS - 1)) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    req_ready <= 1'b1;
                    init_busy <= 1'b0;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Bank read registers hold between reads, so selecting by the held
    // rsp_bank keeps rsp_rdata stable while rsp_valid is low.
    always_comb begin
        rsp_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rsp_bank == BANK_BITS'(b)) begin
                rsp_rdata = rsp_rdata | bank_rdata[b];
            end
        end
    end

endmodule

// File: tb/tb_banked_mem.sv
// Directed table-driven bench for banked_mem with hand-written reset/init sequences.
module tb_banked_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_bank;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    banked_mem dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_bank (rsp_bank),
        .init_busy(init_busy)
    );

    typedef struct {
        logic        valid;
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_bank;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    // Count edges after rst release until req_ready is seen high.
    task automatic wait_ready(input string name, input int exp_edges);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready) break;
        end
        check(name, 32'(n), 32'(exp_edges));
        check({name, "_busy"}, 32'(init_busy), 32'd0);
    endtask

    function automatic vec_t mk(input logic v, input logic w, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                input logic ev, input logic [31:0] er, input logic [1:0] eb);
        vec_t t;
        t.valid = v; t.write = w; t.addr = a; t.wdata = d; t.be = be;
        t.exp_valid = ev; t.exp_rdata = er; t.exp_bank = eb;
        return t;
    endfunction

    initial begin
        // Expected rdata/bank on write or idle rows are the values held from the previous read.
        vecs[0]  = mk(1, 0, 8'h00, 32'h0,        4'hF, 1, 32'h00000000, 2'd0);
        vecs[1]  = mk(1, 0, 8'h3F, 32'h0,        4'hF, 1, 32'h00000000, 2'd0);
        vecs[2]  = mk(1, 0, 8'h40, 32'h0,        4'hF, 1, 32'h00000000, 2'd1);
        vecs[3]  = mk(1, 0, 8'hFF, 32'h0,        4'hF, 1, 32'h00000000, 2'd3);
        vecs[4]  = mk(1, 1, 8'h3C, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, 2'd3);
        vecs[5]  = mk(1, 0, 8'h3C, 32'h0,        4'h0, 1, 32'hDEADBEEF, 2'd0);
        vecs[6]  = mk(1, 0, 8'h7C, 32'h0,        4'hF, 1, 32'h00000000, 2'd1);
        vecs[7]  = mk(1, 1, 8'hC5, 32'hAABBCCDD, 4'hF, 0, 32'h00000000, 2'd1);
        vecs[8]  = mk(1, 1, 8'hC5, 32'h11223344, 4'h5, 0, 32'h00000000, 2'd1);
        vecs[9]  = mk(1, 0, 8'hC5, 32'h0,        4'hF, 1, 32'hAA22CC44, 2'd3);
        vecs[10] = mk(1, 1, 8'h01, 32'h00000001, 4'hF, 0, 32'hAA22CC44, 2'd3);
        vecs[11] = mk(1, 1, 8'h41, 32'h00000041, 4'hF, 0, 32'hAA22CC44, 2'd3);
        vecs[12] = mk(1, 1, 8'h81, 32'h00000081, 4'hF, 0, 32'hAA22CC44, 2'd3);
        vecs[13] = mk(1, 1, 8'hC1, 32'h000000C1, 4'hF, 0, 32'hAA22CC44, 2'd3);
        vecs[14] = mk(1, 0, 8'h01, 32'h0,        4'hF, 1, 32'h00000001, 2'd0);
        vecs[15] = mk(1, 0, 8'h41, 32'h0,        4'hF, 1, 32'h00000041, 2'd1);
        vecs[16] = mk(1, 0, 8'h81, 32'h0,        4'hF, 1, 32'h00000081, 2'd2);
        vecs[17] = mk(1, 0, 8'hC1, 32'h0,        4'hF, 1, 32'h000000C1, 2'd3);
        vecs[18] = mk(0, 0, 8'h01, 32'h0,        4'hF, 0, 32'h000000C1, 2'd3);
        vecs[19] = mk(1, 1, 8'h10, 32'h12345678, 4'hF, 0, 32'h000000C1, 2'd3);
        vecs[20] = mk(1, 0, 8'h10, 32'h0,        4'hF, 1, 32'h12345678, 2'd0);
        vecs[21] = mk(1, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 32'h12345678, 2'd0);
        vecs[22] = mk(1, 0, 8'h10, 32'h0,        4'hF, 1, 32'h12345678, 2'd0);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy",  32'(init_busy), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_bank",  32'(rsp_bank), 32'd0);

        rst = 1'b0;
        wait_ready("init_edges", 64);

        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            req_write = vecs[i].write;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            req_be    = vecs[i].be;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
            check($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_bank", i),  32'(rsp_bank), 32'(vecs[i].exp_bank));
        end
        idle_inputs();
        @(posedge clk);
        #1;
        check("post_valid_drop", 32'(rsp_valid), 32'd0);

        // Reset in the same cycle a read is accepted: response is discarded.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h3C;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_busy",  32'(init_busy), 32'd1);
        rst = 1'b0;

        // Reset at edge 20 of INIT restarts clearing from row 0.
        repeat (20) @(posedge clk);
        #1;
        check("init20_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("reinit_edges", 64);

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h3C;
        @(posedge clk);
        #1;
        idle_inputs();
        check("cleared_valid", 32'(rsp_valid), 32'd1);
        check("cleared_rdata", rsp_rdata, 32'd0);
        check("cleared_bank",  32'(rsp_bank), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
